reg_file_loader: RTL
====================

Name: reg_file_loader

Overview:
- Write-side initiator for the CPU's 8x8 register file.
- Accepts a valid/ready byte stream and writes consecutive registers starting at a programmed base address. Drives the register file's write port (data, address, write enable).
- Used to preload operands at boot/test time, before the control unit takes over the register file ports through an external mux.
- Optionally verifies the load through read port 1.

Parameters:
- DATA_W, 8, register and stream byte width.
- ADDR_W, 3, register address width.
- NUM_REGS, 8, number of registers; address arithmetic wraps modulo NUM_REGS.

Ports:
- clk  input  1  clock; all state changes on posedge.
- reset  input  1  reset, synchronous, active-high.
- start  input  1  one-cycle request to begin a load; sampled only in IDLE.
- base_addr  input  ADDR_W  first register to write; latched on accepted start.
- count  input  ADDR_W+1  number of registers to write, 0..NUM_REGS; values above NUM_REGS clamp to NUM_REGS.
- s_valid  input  1  stream byte valid.
- s_data  input  DATA_W  stream byte.
- s_ready  output  1  loader accepts a byte this cycle.
- rf_in  output  DATA_W  register-file write data (registered).
- rf_inaddress  output  ADDR_W  register-file write address (registered).
- rf_write  output  1  register-file write enable (registered).
- rf_rdaddress  output  ADDR_W  register-file read port 1 address (verify only).
- rf_rddata  input  DATA_W  register-file read port 1 data (verify only).
- busy  output  1  high outside IDLE.
- done  output  1  one-cycle pulse at end of operation.
- error  output  1  sticky verify mismatch; cleared on next accepted start.

Behaviour:
- Reset values: all outputs 0, state IDLE, internal pointer/remaining/checksum 0.
- FSM states: IDLE, LOAD, FLUSH, VERIFY (feature only), DONE.
- IDLE, start=1, clamped count>0:
  - latch base_addr into ptr and clamped count into remaining; clear checksum and error.
  - go LOAD.
- IDLE, start=1, count=0: go DONE directly; no write issued.
- start outside IDLE is ignored.
- LOAD:
  - s_ready=1 combinationally while remaining>0.
  - Beat accepted on a posedge where s_valid & s_ready: at that edge rf_in<=s_data, rf_inaddress<=ptr, rf_write<=1, ptr<=(ptr+1) mod NUM_REGS, remaining<=remaining-1, checksum<=checksum^s_data.
  - The register file captures the write on the following posedge; accept-to-commit latency is 2 edges.
  - A cycle with no accepted beat registers rf_write<=0.
  - Last beat accepted (remaining 1->0): go FLUSH; s_ready is 0 in the next cycle.
  - Wrap: base 6, count 4 writes addresses 6,7,0,1.
- FLUSH: one cycle; rf_write<=0 so the final write commits. Then go VERIFY if enabled, else DONE.
- DONE: done=1 for exactly one cycle, busy still 1; next state IDLE.
- Reset in any state:
  - next cycle is IDLE with rf_write=0.
  - a registered write not yet committed is dropped; the register file also clears on the same reset.
- s_data is ignored whenever s_ready=0.

Optional Feature:
- Macro: REG_FILE_LOADER_VERIFY_EN.
- Defined:
  - VERIFY walks rf_rdaddress from the latched base over the latched count, one address per cycle.
  - rf_rddata for an address is sampled one cycle after that address is driven, covering the register file's read delay.
  - Sampled data is XOR-accumulated.
  - After the last sample, error<=(readback XOR != load checksum); then go DONE.
  - Verify adds count+1 cycles.
- Undefined:
  - no VERIFY state; FLUSH goes to DONE.
  - rf_rdaddress tied 0, error tied 0, rf_rddata unused.

Decomposition:
- Shared package simple_cpu_pkg:
  - DATA_W and ADDR_W constants, NUM_REGS.
  - loader state enum.
- One natural sub-module: xor_checksum (clear, enable, byte in, DATA_W accumulator), instanced for load and readback sums.

Test Plan:
- Base 2, count 3, bytes 0x11,0x22,0x33 streamed back-to-back -> rf_write pulses at addresses 2,3,4 with those data; done one cycle after FLUSH; register file holds 0x11,0x22,0x33 at 2..4.
- Base 6, count 4, bytes 0xA0..0xA3 -> writes to 6,7,0,1; pointer wraps with no extra cycle.
- Base 0, count 2, s_valid toggling 1,0,0,1 -> exactly 2 writes; rf_write low in gap cycles; busy held until done.
- count 0 with start -> done pulses one cycle later; rf_write never asserted. Separately, count 9 -> clamped to 8 beats.
- Reset asserted after 2 of 5 beats accepted -> next cycle IDLE, s_ready=0, rf_write=0; a following start restarts cleanly.
- With REG_FILE_LOADER_VERIFY_EN, load 0x5A at address 3, then force rf_rddata=0x5B -> error=1 with done. Unforced -> error=0.

Source files
------------

// File: rtl/simple_cpu_pkg.sv
// Shared constants and loader state encoding
// for the simple CPU register-file helpers.
package simple_cpu_pkg;

  localparam int CPU_DATA_W   = 8;
  localparam int CPU_ADDR_W   = 3;
  localparam int CPU_NUM_REGS = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_VERIFY,
    S_DONE
  } ldr_state_t;

endpackage

// File: rtl/xor_checksum.sv
// Byte-wide XOR accumulator; clear has priority
// over enable so a restart never folds in stale data.
module xor_checksum
  import simple_cpu_pkg::*;
#(
  parameter int W = CPU_DATA_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] sum
);

  logic [W-1:0] r_sum;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_sum <= '0;
    end else if (en) begin
      r_sum <= r_sum ^ din;
    end
  end

  assign sum = r_sum;

endmodule

// File: rtl/reg_file_loader.sv
// Streams bytes into consecutive register-file entries.
// Readback check enabled by REG_FILE_LOADER_VERIFY_EN.
module reg_file_loader
  import simple_cpu_pkg::*;
#(
  parameter int DATA_W   = CPU_DATA_W,
  parameter int ADDR_W   = CPU_ADDR_W,
  parameter int NUM_REGS = CPU_NUM_REGS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic [DATA_W-1:0] rf_in,
  output logic [ADDR_W-1:0] rf_inaddress,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_rdaddress,
  input  logic [DATA_W-1:0] rf_rddata,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] MAXC = CW'(NUM_REGS);

  function automatic logic [ADDR_W-1:0] add_wrap(
    input logic [ADDR_W-1:0] a,
    input logic [CW-1:0]     b
  );
    int s;
    s = (int'(a) + int'(b)) % NUM_REGS;
    return ADDR_W'(s);
  endfunction

  ldr_state_t        r_state;
  ldr_state_t        w_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic [CW-1:0]     r_rem;
  logic [DATA_W-1:0] r_wdata;
  logic [ADDR_W-1:0] r_waddr;
  logic              r_wen;
  logic [CW-1:0]     w_clamp;
  logic              w_start;
  logic              w_beat;
  logic [DATA_W-1:0] w_ld_sum;

  assign w_clamp = (count > MAXC) ? MAXC : count;
  assign w_start = (r_state == S_IDLE) && start;
  assign s_ready = (r_state == S_LOAD) && (r_rem != '0);
  assign w_beat  = s_valid && s_ready;
  assign busy    = (r_state != S_IDLE);
  assign done    = (r_state == S_DONE);

  assign rf_in        = r_wdata;
  assign rf_inaddress = r_waddr;
  assign rf_write     = r_wen;

  xor_checksum #(.W(DATA_W)) u_ld_sum (
    .clk   (clk),
    .reset (reset),
    .clear (w_start),
    .en    (w_beat),
    .din   (s_data),
    .sum   (w_ld_sum)
  );

`ifdef REG_FILE_LOADER_VERIFY_EN
  logic [ADDR_W-1:0] r_base;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     r_vcnt;
  logic              r_err;
  logic [DATA_W-1:0] w_rb_sum;
  logic              w_vlast;

  assign w_vlast = (r_state == S_VERIFY) &&
                   (r_vcnt == r_cnt);

  // Sample lags the driven address by one cycle.
  xor_checksum #(.W(DATA_W)) u_rb_sum (
    .clk   (clk),
    .reset (reset),
    .clear (w_start),
    .en    ((r_state == S_VERIFY) &&
            (r_vcnt != '0)),
    .din   (rf_rddata),
    .sum   (w_rb_sum)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_base <= '0;
      r_cnt  <= '0;
      r_vcnt <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_start) begin
        r_base <= base_addr;
        r_cnt  <= w_clamp;
        r_err  <= 1'b0;
      end
      if (r_state == S_VERIFY) begin
        r_vcnt <= r_vcnt + CW'(1);
      end else begin
        r_vcnt <= '0;
      end
      if (w_vlast) begin
        r_err <= ((w_rb_sum ^ rf_rddata)
                  != w_ld_sum);
      end
    end
  end

  assign error = r_err;
  assign rf_rdaddress =
    (r_state == S_VERIFY) ?
    add_wrap(r_base, r_vcnt) : '0;
`else
  logic w_unused;
  assign w_unused     = ^{rf_rddata, w_ld_sum};
  assign error        = 1'b0;
  assign rf_rdaddress = '0;
`endif

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_nxt = (w_clamp == '0) ?
                  S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_beat && (r_rem == CW'(1))) begin
          w_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
`ifdef REG_FILE_LOADER_VERIFY_EN
        w_nxt = S_VERIFY;
`else
        w_nxt = S_DONE;
`endif
      end
`ifdef REG_FILE_LOADER_VERIFY_EN
      S_VERIFY: begin
        if (w_vlast) begin
          w_nxt = S_DONE;
        end
      end
`endif
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_rem   <= '0;
      r_wdata <= '0;
      r_waddr <= '0;
      r_wen   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_wen   <= w_beat;
      if (w_start) begin
        r_ptr <= base_addr;
        r_rem <= w_clamp;
      end
      if (w_beat) begin
        r_wdata <= s_data;
        r_waddr <= r_ptr;
        r_ptr   <= add_wrap(r_ptr, CW'(1));
        r_rem   <= r_rem - CW'(1);
      end
    end
  end

endmodule
